// File: rtl/hp_arb_pkg.sv
// ----------------------------------------------------------------------------
// hp_arb_pkg
// Shared types for the HP read-port arbiter: the arbiter FSM state encoding,
// the requester identity type, and the width of one owner-FIFO entry
// ({owner, arlen}).
// Ports: none (package).
// ----------------------------------------------------------------------------
package hp_arb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_AR   = 1'b1
   } state_t;

   // Requester 0 is the IFM read DMA, requester 1 the weight read DMA.
   typedef enum logic [0:0] {
      REQ_IFM = 1'b0,
      REQ_WGT = 1'b1
   } owner_t;

   // One order-FIFO entry: owner bit on top of the burst length.
   function automatic int order_entry_w(input int len_w);
      return len_w + 1;
   endfunction

endpackage

// File: rtl/hp_rd_order_fifo.sv
// ----------------------------------------------------------------------------
// hp_rd_order_fifo
// Small synchronous FIFO recording, in issue order, which requester owns each
// outstanding read burst. Push and pop may occur in the same cycle; a push
// into a full FIFO is taken only when a pop frees a slot in that cycle.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (empties the FIFO)
//   push, push_data   write strobe and entry
//   pop               read strobe (ignored when empty)
//   full, empty       occupancy flags
//   count             number of stored entries (0..DEPTH)
//   head              oldest entry (valid when !empty)
// ----------------------------------------------------------------------------
module hp_rd_order_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Qualify strobes against occupancy.
   always_comb begin
      do_pop_s  = pop & (count_r != {(PTR_W+1){1'b0}});
      do_push_s = push & ((count_r != CNT_FULL) | do_pop_s);
   end

   // Pointer and occupancy update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are don't-care while not counted as occupied.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;
   assign full  = (count_r == CNT_FULL);
   assign empty = (count_r == {(PTR_W+1){1'b0}});

endmodule

// File: rtl/hp_rd_arbiter.sv
// ----------------------------------------------------------------------------
// hp_rd_arbiter
// Shares one AXI3 HP read port (AR + R channels) between the IFM read DMA
// (requester 0) and the weight read DMA (requester 1). Round-robin grant on
// AR; an in-order owner FIFO steers R beats back to the issuing requester.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_arvalid/araddr/arlen  requester N address request (arlen = beats-1)
//   reqN_arready               one-cycle grant pulse to requester N
//   m_ar*                      HP port address channel
//   m_rvalid/rdata/rlast       HP port read data in
//   m_rready                   HP port read ready
//   rN_valid/data/last/ready   read beats routed to requester N
//   outst_cnt                  bursts issued and not yet completed
//   busy                       address phase active or bursts outstanding
//   err                        sticky R-channel protocol error
// ----------------------------------------------------------------------------
module hp_rd_arbiter
   import hp_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int LEN_W     = 4,
   parameter int MAX_OUTST = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req0_arvalid,
   input  logic [ADDR_W-1:0]            req0_araddr,
   input  logic [LEN_W-1:0]             req0_arlen,
   output logic                         req0_arready,
   input  logic                         req1_arvalid,
   input  logic [ADDR_W-1:0]            req1_araddr,
   input  logic [LEN_W-1:0]             req1_arlen,
   output logic                         req1_arready,
   output logic                         m_arvalid,
   output logic [ADDR_W-1:0]            m_araddr,
   output logic [LEN_W-1:0]             m_arlen,
   input  logic                         m_arready,
   input  logic                         m_rvalid,
   input  logic [DATA_W-1:0]            m_rdata,
   input  logic                         m_rlast,
   output logic                         m_rready,
   output logic                         r0_valid,
   output logic [DATA_W-1:0]            r0_data,
   output logic                         r0_last,
   input  logic                         r0_ready,
   output logic                         r1_valid,
   output logic [DATA_W-1:0]            r1_data,
   output logic                         r1_last,
   input  logic                         r1_ready,
   output logic [$clog2(MAX_OUTST):0]   outst_cnt,
   output logic                         busy,
   output logic                         err
);

   localparam int EW = order_entry_w(LEN_W);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t           state_r;
   owner_t           rr_ptr_r;
   owner_t           owner_r;
   logic [LEN_W-1:0] beat_cnt_r;

   logic             grant_s;
   owner_t           winner_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [EW-1:0]    head_s;
   owner_t           head_owner_s;
   logic [LEN_W-1:0] head_len_s;
   logic             head_ready_s;
   logic             owner0_s;
   logic             owner1_s;
   logic             push_s;
   logic             pop_s;
   logic             r_hs_s;

   // Grant decision: only in IDLE, only with a free FIFO slot; on a tie the
   // round-robin pointer picks. Held off during reset.
   always_comb begin
      grant_s  = 1'b0;
      winner_s = rr_ptr_r;
      if (rst_n && (state_r == ST_IDLE) && !fifo_full_s) begin
         if (req0_arvalid && req1_arvalid) begin
            grant_s  = 1'b1;
            winner_s = rr_ptr_r;
         end else if (req0_arvalid) begin
            grant_s  = 1'b1;
            winner_s = REQ_IFM;
         end else if (req1_arvalid) begin
            grant_s  = 1'b1;
            winner_s = REQ_WGT;
         end else begin
            grant_s  = 1'b0;
            winner_s = rr_ptr_r;
         end
      end else begin
         grant_s  = 1'b0;
         winner_s = rr_ptr_r;
      end
   end

   assign req0_arready = grant_s & (winner_s == REQ_IFM);
   assign req1_arready = grant_s & (winner_s == REQ_WGT);

   // Address-phase FSM: capture the winner in IDLE, present it in AR until
   // the HP port accepts, then hand priority to the other requester.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         rr_ptr_r  <= REQ_IFM;
         owner_r   <= REQ_IFM;
         m_arvalid <= 1'b0;
         m_araddr  <= {ADDR_W{1'b0}};
         m_arlen   <= {LEN_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_s) begin
                  owner_r   <= winner_s;
                  m_araddr  <= (winner_s == REQ_WGT) ? req1_araddr : req0_araddr;
                  m_arlen   <= (winner_s == REQ_WGT) ? req1_arlen  : req0_arlen;
                  m_arvalid <= 1'b1;
                  state_r   <= ST_AR;
               end
            end
            ST_AR: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  rr_ptr_r  <= owner_t'(~owner_r);
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               m_arvalid <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign push_s = (state_r == ST_AR) & m_arvalid & m_arready;

   hp_rd_order_fifo #(
      .DEPTH (MAX_OUTST),
      .WIDTH (EW)
   ) u_order_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data ({owner_r, m_arlen}),
      .pop       (pop_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (outst_cnt),
      .head      (head_s)
   );

   // R-channel steering from the head of the owner FIFO, no added latency.
   always_comb begin
      head_owner_s = owner_t'(head_s[LEN_W]);
      head_len_s   = head_s[LEN_W-1:0];
      owner0_s     = ~fifo_empty_s & (head_owner_s == REQ_IFM);
      owner1_s     = ~fifo_empty_s & (head_owner_s == REQ_WGT);
      head_ready_s = (owner0_s & r0_ready) | (owner1_s & r1_ready);
      m_rready     = head_ready_s;
      r_hs_s       = m_rvalid & head_ready_s;
      pop_s        = r_hs_s & m_rlast;
      r0_valid     = m_rvalid & owner0_s;
      r0_last      = m_rlast  & owner0_s;
      r1_valid     = m_rvalid & owner1_s;
      r1_last      = m_rlast  & owner1_s;
   end

   assign r0_data = m_rdata;
   assign r1_data = m_rdata;

   // Beat counting against the recorded burst length; rlast must land
   // exactly on beat index == arlen. Data with nothing outstanding is an
   // error as well. err only clears on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt_r <= {LEN_W{1'b0}};
         err        <= 1'b0;
      end else begin
         if (r_hs_s) begin
            if (m_rlast) begin
               beat_cnt_r <= {LEN_W{1'b0}};
               if (beat_cnt_r != head_len_s) begin
                  err <= 1'b1;
               end
            end else begin
               beat_cnt_r <= beat_cnt_r + LEN_ONE;
               if (beat_cnt_r == head_len_s) begin
                  err <= 1'b1;
               end
            end
         end
         if (m_rvalid && fifo_empty_s) begin
            err <= 1'b1;
         end
      end
   end

   assign busy = (state_r != ST_IDLE) | (|outst_cnt);

endmodule

// File: tb/tb_hp_rd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_hp_rd_arbiter
// Directed self-checking bench for hp_rd_arbiter (default parameters,
// MAX_OUTST = 4). Inputs change 1 time unit after the rising edge; outputs are
// checked 1 time unit later.
// ----------------------------------------------------------------------------
module tb_hp_rd_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0_arvalid, req1_arvalid;
   logic [31:0] req0_araddr,  req1_araddr;
   logic [3:0]  req0_arlen,   req1_arlen;
   logic        req0_arready, req1_arready;
   logic        m_arvalid;
   logic [31:0] m_araddr;
   logic [3:0]  m_arlen;
   logic        m_arready;
   logic        m_rvalid;
   logic [63:0] m_rdata;
   logic        m_rlast;
   logic        m_rready;
   logic        r0_valid, r1_valid;
   logic [63:0] r0_data,  r1_data;
   logic        r0_last,  r1_last;
   logic        r0_ready, r1_ready;
   logic [2:0]  outst_cnt;
   logic        busy;
   logic        err;

   int n_cmp = 0;
   int n_err = 0;

   hp_rd_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0_arvalid (req0_arvalid),
      .req0_araddr  (req0_araddr),
      .req0_arlen   (req0_arlen),
      .req0_arready (req0_arready),
      .req1_arvalid (req1_arvalid),
      .req1_araddr  (req1_araddr),
      .req1_arlen   (req1_arlen),
      .req1_arready (req1_arready),
      .m_arvalid    (m_arvalid),
      .m_araddr     (m_araddr),
      .m_arlen      (m_arlen),
      .m_arready    (m_arready),
      .m_rvalid     (m_rvalid),
      .m_rdata      (m_rdata),
      .m_rlast      (m_rlast),
      .m_rready     (m_rready),
      .r0_valid     (r0_valid),
      .r0_data      (r0_data),
      .r0_last      (r0_last),
      .r0_ready     (r0_ready),
      .r1_valid     (r1_valid),
      .r1_data      (r1_data),
      .r1_last      (r1_last),
      .r1_ready     (r1_ready),
      .outst_cnt    (outst_cnt),
      .busy         (busy),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   initial begin
      int own_e [5];
      int len_e [5];
      logic [63:0] d;
      own_e = '{0, 1, 0, 1, 0};
      len_e = '{4, 4, 4, 4, 1};

      rst_n = 1'b0;
      req0_arvalid = 1'b1; req0_araddr = 32'h1234_5678; req0_arlen = 4'd0;
      req1_arvalid = 1'b0; req1_araddr = 32'h0;         req1_arlen = 4'd0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 64'h0; m_rlast = 1'b0;
      r0_ready = 1'b1; r1_ready = 1'b1;

      // ---- reset state (request pending during reset must not be granted)
      cyc(); cyc();
      chk("rst_arready0", req0_arready, 1'b0);
      chk("rst_arvalid",  m_arvalid, 1'b0);
      chk("rst_araddr",   m_araddr, 32'h0);
      chk("rst_arlen",    m_arlen, 4'd0);
      chk("rst_rready",   m_rready, 1'b0);
      chk("rst_outst",    outst_cnt, 3'd0);
      chk("rst_busy",     busy, 1'b0);
      chk("rst_err",      err, 1'b0);
      req0_arvalid = 1'b0;
      rst_n = 1'b1;

      // ---- T1: single burst, req0 arlen=3
      req0_arvalid = 1'b1; req0_araddr = 32'h1000_0000; req0_arlen = 4'd3; m_arready = 1'b1;
      #1;
      chk("t1_arready0", req0_arready, 1'b1);
      chk("t1_arready1", req1_arready, 1'b0);
      cyc();
      req0_arvalid = 1'b0;
      #1;
      chk("t1_m_arvalid", m_arvalid, 1'b1);
      chk("t1_m_araddr",  m_araddr, 32'h1000_0000);
      chk("t1_m_arlen",   m_arlen, 4'd3);
      chk("t1_outst_pre", outst_cnt, 3'd0);
      chk("t1_busy",      busy, 1'b1);
      chk("t1_no_regrant", req0_arready, 1'b0);
      cyc();
      chk("t1_arvalid_done", m_arvalid, 1'b0);
      chk("t1_outst_1",      outst_cnt, 3'd1);
      for (int i = 0; i < 4; i++) begin
         m_rvalid = 1'b1; m_rdata = 64'hA0 + 64'(i); m_rlast = (i == 3);
         d = 64'hA0 + 64'(i);
         #1;
         chk("t1_r0_valid", r0_valid, 1'b1);
         chk("t1_r1_valid", r1_valid, 1'b0);
         chk("t1_r0_data",  r0_data, d);
         chk("t1_r0_last",  r0_last, (i == 3) ? 1'b1 : 1'b0);
         chk("t1_m_rready", m_rready, 1'b1);
         cyc();
      end
      m_rvalid = 1'b0; m_rlast = 1'b0;
      #1;
      chk("t1_outst_0", outst_cnt, 3'd0);
      chk("t1_err",     err, 1'b0);
      chk("t1_idle",    busy, 1'b0);

      // ---- T2: both requesters continuously valid, arlen=4; fill FIFO
      do_reset();
      req0_arvalid = 1'b1; req0_araddr = 32'h2000_0000; req0_arlen = 4'd4;
      req1_arvalid = 1'b1; req1_araddr = 32'h3000_0000; req1_arlen = 4'd4;
      m_arready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t2_grant0", req0_arready, (k % 2 == 0) ? 1'b1 : 1'b0);
         chk("t2_grant1", req1_arready, (k % 2 == 1) ? 1'b1 : 1'b0);
         cyc();
         #1;
         chk("t2_araddr", m_araddr, (k % 2 == 0) ? 32'h2000_0000 : 32'h3000_0000);
         chk("t2_arlen",  m_arlen, 4'd4);
         cyc();
      end
      // ---- T4: FIFO full stalls the requester
      req1_arvalid = 1'b0; req0_araddr = 32'h4000_0000; req0_arlen = 4'd1;
      #1;
      chk("t4_outst_peak", outst_cnt, 3'd4);
      chk("t4_full_stall", req0_arready, 1'b0);
      cyc();
      chk("t4_full_stall2", req0_arready, 1'b0);
      for (int b = 0; b < 5; b++) begin
         for (int i = 0; i <= len_e[b]; i++) begin
            d = 64'hB000 + 64'(b * 16 + i);
            m_rvalid = 1'b1; m_rdata = d; m_rlast = (i == len_e[b]);
            #1;
            if (own_e[b] == 0) begin
               chk("t2_r0_valid", r0_valid, 1'b1);
               chk("t2_r1_idle",  r1_valid, 1'b0);
               chk("t2_r0_data",  r0_data, d);
               chk("t2_r0_last",  r0_last, (i == len_e[b]) ? 1'b1 : 1'b0);
            end else begin
               chk("t2_r1_valid", r1_valid, 1'b1);
               chk("t2_r0_idle",  r0_valid, 1'b0);
               chk("t2_r1_data",  r1_data, d);
               chk("t2_r1_last",  r1_last, (i == len_e[b]) ? 1'b1 : 1'b0);
            end
            if (b == 0 && i == len_e[b]) begin
               chk("t4_pop_no_grant", req0_arready, 1'b0);
            end
            cyc();
         end
         m_rvalid = 1'b0; m_rlast = 1'b0;
         if (b == 0) begin
            #1;
            chk("t4_outst_3",      outst_cnt, 3'd3);
            chk("t4_grant_after",  req0_arready, 1'b1);
            cyc();
            req0_arvalid = 1'b0;
            #1;
            chk("t4_araddr", m_araddr, 32'h4000_0000);
            cyc();
            chk("t4_outst_4_again", outst_cnt, 3'd4);
         end
      end
      #1;
      chk("t2_outst_0", outst_cnt, 3'd0);
      chk("t2_err",     err, 1'b0);

      // ---- T3: m_arready held low for 10 cycles (rr_ptr now favours req1)
      req1_arvalid = 1'b1; req1_araddr = 32'h5000_0040; req1_arlen = 4'd2;
      m_arready = 1'b0;
      #1;
      chk("t3_grant1", req1_arready, 1'b1);
      cyc();
      req1_arvalid = 1'b0;
      req0_arvalid = 1'b1; req0_araddr = 32'h6000_0000; req0_arlen = 4'd0;
      for (int j = 0; j < 10; j++) begin
         #1;
         chk("t3_arvalid_hold", m_arvalid, 1'b1);
         chk("t3_araddr_hold",  m_araddr, 32'h5000_0040);
         chk("t3_arlen_hold",   m_arlen, 4'd2);
         chk("t3_no_grant0",    req0_arready, 1'b0);
         cyc();
      end
      m_arready = 1'b1;
      cyc();
      chk("t3_grant0_after", req0_arready, 1'b1);
      cyc();
      req0_arvalid = 1'b0;
      #1;
      chk("t3_araddr0", m_araddr, 32'h6000_0000);
      cyc();
      chk("t3_outst_2", outst_cnt, 3'd2);

      // ---- T5: backpressure from r1 at the FIFO head
      r1_ready = 1'b0; r0_ready = 1'b1;
      m_rvalid = 1'b1; m_rdata = 64'hD0; m_rlast = 1'b0;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk("t5_rready_low", m_rready, 1'b0);
         chk("t5_r0_nothing", r0_valid, 1'b0);
         chk("t5_r1_valid",   r1_valid, 1'b1);
         cyc();
      end
      chk("t5_outst_hold", outst_cnt, 3'd2);
      r1_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = 64'hD0 + 64'(i);
         m_rdata = d; m_rlast = (i == 2);
         #1;
         chk("t5_rready_high", m_rready, 1'b1);
         chk("t5_r1_data",     r1_data, d);
         chk("t5_r1_last",     r1_last, (i == 2) ? 1'b1 : 1'b0);
         cyc();
      end
      m_rdata = 64'hE0; m_rlast = 1'b1;
      #1;
      chk("t5_r0_valid", r0_valid, 1'b1);
      chk("t5_r0_last",  r0_last, 1'b1);
      chk("t5_r1_off",   r1_valid, 1'b0);
      cyc();
      m_rvalid = 1'b0; m_rlast = 1'b0;
      #1;
      chk("t5_outst_0", outst_cnt, 3'd0);
      chk("t5_err",     err, 1'b0);

      // ---- T6a: early rlast (beat 2 of an arlen=3 burst)
      req0_arvalid = 1'b1; req0_araddr = 32'h7000_0000; req0_arlen = 4'd3;
      m_arready = 1'b1;
      cyc();
      req0_arvalid = 1'b0;
      cyc();
      m_rvalid = 1'b1; m_rdata = 64'hF0; m_rlast = 1'b0;
      cyc();
      m_rdata = 64'hF1; m_rlast = 1'b1;
      #1;
      chk("t6_err_before", err, 1'b0);
      cyc();
      m_rvalid = 1'b0; m_rlast = 1'b0;
      #1;
      chk("t6_err_early_last", err, 1'b1);
      chk("t6_outst_popped",   outst_cnt, 3'd0);
      cyc();
      chk("t6_err_sticky", err, 1'b1);
      do_reset();
      chk("t6_err_cleared", err, 1'b0);

      // ---- T6b: spurious data with an empty FIFO
      m_rvalid = 1'b1; m_rdata = 64'h5A; m_rlast = 1'b0;
      #1;
      chk("t6_spur_rready", m_rready, 1'b0);
      chk("t6_spur_r0",     r0_valid, 1'b0);
      chk("t6_spur_r1",     r1_valid, 1'b0);
      cyc();
      m_rvalid = 1'b0;
      #1;
      chk("t6_spur_err", err, 1'b1);
      do_reset();

      // ---- T6c: reset in the middle of a burst and an address phase
      req1_arvalid = 1'b1; req1_araddr = 32'h8000_0000; req1_arlen = 4'd3;
      m_arready = 1'b1;
      cyc();
      req1_arvalid = 1'b0;
      cyc();
      m_rvalid = 1'b1; m_rdata = 64'h77; m_rlast = 1'b0;
      #1;
      chk("t6_mid_r1_valid", r1_valid, 1'b1);
      req0_arvalid = 1'b1; req0_araddr = 32'h9000_0000; req0_arlen = 4'd2;
      m_arready = 1'b0;
      cyc();
      chk("t6_mid_in_ar", m_arvalid, 1'b1);
      rst_n = 1'b0;
      cyc();
      chk("t6_rst_arvalid", m_arvalid, 1'b0);
      chk("t6_rst_araddr",  m_araddr, 32'h0);
      chk("t6_rst_arlen",   m_arlen, 4'd0);
      chk("t6_rst_outst",   outst_cnt, 3'd0);
      chk("t6_rst_busy",    busy, 1'b0);
      chk("t6_rst_err",     err, 1'b0);
      chk("t6_rst_r1",      r1_valid, 1'b0);
      chk("t6_rst_rready",  m_rready, 1'b0);
      chk("t6_rst_arready", req0_arready, 1'b0);
      rst_n = 1'b1; m_rvalid = 1'b0; req0_arvalid = 1'b0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
